// File: rtl/demux1to16_7b_reg.sv
// Registered 1-to-16 demux for 7-bit segment patterns with single, burst-fill and clear-sweep writes.
// Optional accepted-write counter on WrCount when WRITE_COUNT_EN is defined.

module demux_slot #(
    parameter int              WIDTH     = 7,
    parameter logic [WIDTH-1:0] CLEAR_VAL = 7'h7F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] slot_q, slot_d;

    always_comb slot_d = we ? d : slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_q <= CLEAR_VAL;
        else        slot_q <= slot_d;
    end

    assign q = slot_q;
endmodule

module demux1to16_7b_reg #(
    parameter int              WIDTH     = 7,
    parameter logic [WIDTH-1:0] CLEAR_VAL = 7'h7F
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [3:0]       S,
    input  logic [WIDTH-1:0] W,
    input  logic             Valid,
    output logic             Ready,
    input  logic             Burst,
    input  logic             Clear,
    output logic             Busy,
    output logic [WIDTH-1:0] F0, F1, F2, F3, F4, F5, F6, F7,
    output logic [WIDTH-1:0] F8, F9, F10, F11, F12, F13, F14, F15
`ifdef WRITE_COUNT_EN
    ,
    output logic [7:0]       WrCount
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_CLEAR} state_e;

    state_e            state_q, state_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              accept;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [15:0]       slot_we;
    logic [15:0][WIDTH-1:0] f_q;

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= 4'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and write routing
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = S;
        wr_data = W;
        case (state_q)
            ST_IDLE: begin
                if (Clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = 4'd0;
                end else if (Burst) begin
                    state_d = ST_BURST;
                    ptr_d   = S;
                    cnt_d   = 5'd0;
                    if (accept) begin
                        wr_en = 1'b1;
                        ptr_d = S + 4'd1;
                        cnt_d = 5'd1;
                    end
                end else if (accept) begin
                    wr_en = 1'b1;
                end
            end
            ST_BURST: begin
                if (Clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = 4'd0;
                end else if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q;
                    ptr_d   = ptr_q + 4'd1;
                    cnt_d   = (cnt_q >= 5'd16) ? 5'd16 : cnt_q + 5'd1;
                    if (cnt_d == 5'd16) state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
                wr_data = CLEAR_VAL;
                ptr_d   = ptr_q + 4'd1;
                if (ptr_q == 4'd15) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; Ready is held low while reset is asserted
    always_comb begin
        Ready  = Resetn & (state_q != ST_CLEAR) & ~Clear;
        Busy   = (state_q != ST_IDLE);
        accept = Valid & Ready;
    end

    always_comb begin
        slot_we = '0;
        slot_we[wr_addr] = wr_en;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            demux_slot #(.WIDTH(WIDTH), .CLEAR_VAL(CLEAR_VAL)) u_slot (
                .clk   (Clock),
                .rst_n (Resetn),
                .we    (slot_we[gi]),
                .d     (wr_data),
                .q     (f_q[gi])
            );
        end
    endgenerate

    assign F0  = f_q[0];  assign F1  = f_q[1];  assign F2  = f_q[2];  assign F3  = f_q[3];
    assign F4  = f_q[4];  assign F5  = f_q[5];  assign F6  = f_q[6];  assign F7  = f_q[7];
    assign F8  = f_q[8];  assign F9  = f_q[9];  assign F10 = f_q[10]; assign F11 = f_q[11];
    assign F12 = f_q[12]; assign F13 = f_q[13]; assign F14 = f_q[14]; assign F15 = f_q[15];

`ifdef WRITE_COUNT_EN
    logic [7:0] wr_cnt_q, wr_cnt_d;

    always_comb wr_cnt_d = (accept && wr_cnt_q != 8'hFF) ? wr_cnt_q + 8'd1 : wr_cnt_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) wr_cnt_q <= 8'd0;
        else         wr_cnt_q <= wr_cnt_d;
    end

    assign WrCount = wr_cnt_q;
`endif
endmodule

// File: tb/tb_demux1to16_7b_reg.sv
// Randomized bench for demux1to16_7b_reg against a slot-array/remaining-beats model.
// Define WRITE_COUNT_EN for both files to also check WrCount.

module tb_demux1to16_7b_reg;
    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic [3:0] S = '0;
    logic [6:0] W = '0;
    logic       Valid = 1'b0, Burst = 1'b0, Clear = 1'b0;
    logic       Ready, Busy;
    logic [6:0] F0, F1, F2, F3, F4, F5, F6, F7, F8, F9, F10, F11, F12, F13, F14, F15;
`ifdef WRITE_COUNT_EN
    logic [7:0] WrCount;
`endif

    demux1to16_7b_reg dut (
        .Clock(Clock), .Resetn(Resetn), .S(S), .W(W), .Valid(Valid), .Ready(Ready),
        .Burst(Burst), .Clear(Clear), .Busy(Busy),
        .F0(F0), .F1(F1), .F2(F2), .F3(F3), .F4(F4), .F5(F5), .F6(F6), .F7(F7),
        .F8(F8), .F9(F9), .F10(F10), .F11(F11), .F12(F12), .F13(F13), .F14(F14), .F15(F15)
`ifdef WRITE_COUNT_EN
        , .WrCount(WrCount)
`endif
    );

    always #5 Clock = ~Clock;

    logic [6:0] dut_f [16];
    always_comb begin
        dut_f[0] = F0;   dut_f[1] = F1;   dut_f[2] = F2;   dut_f[3] = F3;
        dut_f[4] = F4;   dut_f[5] = F5;   dut_f[6] = F6;   dut_f[7] = F7;
        dut_f[8] = F8;   dut_f[9] = F9;   dut_f[10] = F10; dut_f[11] = F11;
        dut_f[12] = F12; dut_f[13] = F13; dut_f[14] = F14; dut_f[15] = F15;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 filling a burst, 2 sweeping; "left" = beats or slots still to go
    logic [6:0] m_f [16];
    int         m_mode, m_next, m_left, m_cnt;
    logic       m_ready;
    assign m_ready = Resetn && (m_mode != 2) && !Clear;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 16; i++) m_f[i] <= 7'h7F;
            m_mode <= 0; m_next <= 0; m_left <= 0; m_cnt <= 0;
        end else begin
            if (Valid && m_ready && m_cnt < 255) m_cnt <= m_cnt + 1;
            case (m_mode)
                0: if (Clear) begin
                       m_mode <= 2; m_next <= 0; m_left <= 16;
                   end else if (Burst) begin
                       m_mode <= 1;
                       if (Valid) begin
                           m_f[S] <= W; m_next <= (S + 1) % 16; m_left <= 15;
                       end else begin
                           m_next <= S; m_left <= 16;
                       end
                   end else if (Valid) m_f[S] <= W;
                1: if (Clear) begin
                       m_mode <= 2; m_next <= 0; m_left <= 16;
                   end else if (Valid) begin
                       m_f[m_next] <= W; m_next <= (m_next + 1) % 16; m_left <= m_left - 1;
                       if (m_left == 1) m_mode <= 0;
                   end
                default: begin
                       m_f[m_next] <= 7'h7F; m_next <= (m_next + 1) % 16; m_left <= m_left - 1;
                       if (m_left == 1) m_mode <= 0;
                   end
            endcase
        end
    end

    // Compare process: outputs sampled on the falling edge
    always @(negedge Clock) begin
        for (int i = 0; i < 16; i++) chk($sformatf("F%0d", i), dut_f[i], m_f[i]);
        chk("Ready", Ready, m_ready);
        chk("Busy", Busy, Resetn ? (m_mode != 0) : 0);
`ifdef WRITE_COUNT_EN
        chk("WrCount", WrCount, m_cnt);
`endif
    end

    task automatic step();
        @(posedge Clock); #1;
    endtask

    task automatic idle_inputs();
        Valid = 0; Burst = 0; Clear = 0;
    endtask

    initial begin
        repeat (2) step();
        @(negedge Clock); #1;
        chk("rst_ready_low", Ready, 0);
        step(); Resetn = 1;

        // Reset state
        @(negedge Clock); #1;
        for (int i = 0; i < 16; i++) chk("t1_slot", dut_f[i], 7'h7F);
        chk("t1_ready", Ready, 1); chk("t1_busy", Busy, 0);

        // Single write
        step(); S = 4'hA; W = 7'h12; Valid = 1;
        step(); idle_inputs();
        @(negedge Clock); #1;
        chk("t2_F10", F10, 7'h12); chk("t2_F9", F9, 7'h7F); chk("t2_F11", F11, 7'h7F);

        // Burst from 14 with beat on the start cycle, wraps mid-burst
        step(); Burst = 1; S = 4'hE; Valid = 1; W = 0;
        step(); Burst = 0; S = 4'h3;
        for (int i = 1; i < 16; i++) begin W = 7'(i); step(); end
        idle_inputs();
        @(negedge Clock); #1;
        chk("t3_F14", F14, 0); chk("t3_F15", F15, 1); chk("t3_F0", F0, 2);
        chk("t3_F13", F13, 15); chk("t3_busy", Busy, 0);

        // Gapped burst from 0, start cycle without a beat
        step(); Burst = 1; S = 0; Valid = 0;
        step(); Burst = 0;
        for (int i = 0; i < 16; i++) begin
            Valid = 1; W = 7'(32 + i); step();
            Valid = 0; step();
        end
        @(negedge Clock); #1;
        for (int i = 0; i < 16; i++) chk("t4_slot", dut_f[i], 32 + i);
        chk("t4_busy", Busy, 0);

        // Clear on burst beat 5
        step(); Burst = 1; S = 3; Valid = 1; W = 7'h55;
        step(); Burst = 0;
        for (int i = 0; i < 3; i++) begin W = 7'(i + 1); step(); end
        Clear = 1; W = 7'h66;
        @(negedge Clock); #1;
        chk("t5_ready_drop", Ready, 0);
        step(); Clear = 0;
        repeat (16) step();
        Valid = 0;
        @(negedge Clock); #1;
        for (int i = 0; i < 16; i++) chk("t5_slot", dut_f[i], 7'h7F);
        chk("t5_busy", Busy, 0);

        // Reset in the middle of a clear sweep
        step(); S = 5; W = 7'h01; Valid = 1;
        step(); Valid = 0; Clear = 1;
        step(); Clear = 0;
        repeat (5) step();
        #2 Resetn = 0;
        #1;
        chk("t6_F5", F5, 7'h7F); chk("t6_busy", Busy, 0);
        step(); Resetn = 1;

`ifdef WRITE_COUNT_EN
        Valid = 1;
        for (int i = 0; i < 300; i++) begin S = 4'($urandom); W = 7'($urandom); step(); end
        Valid = 0;
        @(negedge Clock); #1;
        chk("t6_wrcount_sat", WrCount, 255);
        step(); Resetn = 0; step(); Resetn = 1;
`endif

        // Random traffic with occasional async reset
        for (int c = 0; c < 4000; c++) begin
            S     = 4'($urandom);
            W     = 7'($urandom);
            Valid = ($urandom % 3) != 0;
            Burst = ($urandom % 12) == 0;
            Clear = ($urandom % 60) == 0;
            if (($urandom % 700) == 0) begin
                #2 Resetn = 0;
                step(); Resetn = 1;
            end else step();
        end

        idle_inputs();
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
